write_burst_gen: RTL and testbench
==================================

Name: write_burst_gen

Overview:
Next-generation BRAM write-address/enable generator for the arbiter write path. It writes one tile per start pulse, as a burst of a runtime-programmable length into one of NUM_BANKS output banks. Each accepted data beat uses a valid/ready handshake, so upstream stalls are tolerated. Successive tiles rotate across banks, and a tile base pointer with a programmable stride advances as they do. Abort and deferred pointer-reset control are included.

Parameters:
NUM_BANKS, 2, number of BRAM banks driven; tiles rotate bank 0..NUM_BANKS-1 (>=1).
ADDR_WIDTH, 11, per-bank BRAM address width; all address arithmetic is modulo 2^ADDR_WIDTH.
MAX_BURST, 16, largest legal cfg_burst_len; LEN_W = $clog2(MAX_BURST+1) (derived localparam).
TILE_CNT_W, 16, width of the completed-tile counter.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous reset, active-high.
start_write  in  1  pulse; starts a tile when in IDLE, otherwise ignored.
reset_addr_counter  in  1  pulse; reloads pointers (see Behaviour).
abort  in  1  pulse; cancels the in-flight burst.
cfg_base_addr  in  ADDR_WIDTH  tile base loaded by reset_addr_counter.
cfg_burst_len  in  LEN_W  beats per tile; sampled on accepted start.
cfg_tile_stride  in  ADDR_WIDTH  base increment applied per full bank rotation.
in_valid  in  1  upstream data beat valid.
in_ready  out  1  beat accepted when in_valid && in_ready.
bram_addr  out  ADDR_WIDTH  address for the active bank.
bram_we  out  NUM_BANKS  one-hot write enable (en+we); zero when no beat is accepted.
bank_sel  out  max(1,$clog2(NUM_BANKS))  current bank index.
busy  out  1  high in WRITING and DONE.
write_done  out  1  one-cycle pulse at end of tile.
tile_count  out  TILE_CNT_W  tiles completed since reset/pointer reload; wraps.

Behaviour:
- Reset (rst sampled high at the clock edge) forces the following values: state IDLE, tile_base=0, bank_ptr=0, offset=0, tile_count=0, pending_rst=0, len_q=0. Resulting outputs: bram_we=0, in_ready=0, busy=0, write_done=0, bram_addr=0, bank_sel=0. Reset mid-burst drops the burst without a write_done.
- States: IDLE, WRITING, DONE.
- IDLE:
  - start_write && cfg_burst_len!=0: latch len_q, go to WRITING.
  - cfg_burst_len==0 or cfg_burst_len>MAX_BURST: start is ignored and the state stays IDLE.
- WRITING:
  - in_ready=1.
  - Accepted beat: bram_we[bank_ptr]=1 combinationally in the same cycle, and offset increments.
  - in_valid=0: no write, offset holds (stall of unbounded length).
  - Beat accepted with offset==len_q-1: go to DONE.
  - Minimum tile time is len_q+2 cycles from start to return to IDLE.
- DONE:
  - write_done=1, in_ready=0, and the state returns to IDLE.
  - offset clears.
  - tile_count increments.
  - bank_ptr advances; on wrap from NUM_BANKS-1 to 0, tile_base += cfg_tile_stride (modulo 2^ADDR_WIDTH).
  - start_write in DONE is ignored.
- Address: bram_addr = (tile_base + offset) mod 2^ADDR_WIDTH, driven combinationally in every state. bank_sel = bank_ptr.
- reset_addr_counter:
  - In IDLE: next cycle tile_base=cfg_base_addr, bank_ptr=0, tile_count=0.
  - In WRITING: sets pending_rst; the burst continues unchanged.
  - In DONE, or when pending_rst is set at DONE: the reload replaces the normal advance (reload wins), tile_count=0, write_done still pulses, pending_rst clears.
- abort:
  - In WRITING: the next state is IDLE. No write_done, pointers and tile_count unchanged, offset clears. Beats already written are not undone. A beat accepted in the abort cycle is still written.
  - If abort and the final beat coincide, abort wins: no DONE.
  - In IDLE/DONE: no effect.
- abort and reset_addr_counter in the same WRITING cycle: the state goes to IDLE and the pointer reload is applied at that edge.
- NUM_BANKS=1: bram_we is 1 bit, and tile_base advances every tile.

Decomposition:
- Package write_gen_pkg holds:
  - state enum (IDLE=2'b00, WRITING=2'b01, DONE=2'b10);
  - bank-index width function;
  - LEN_W derivation helper.
- One natural sub-module, write_tile_ptr. It owns tile_base, bank_ptr, tile_count and pending_rst, and takes the advance / reload / pending-request inputs.
- The top block keeps the FSM, the offset counter and the output decode.

Test Plan:
- NUM_BANKS=2, base=0x010, len=4, stride=8, continuous valid, 4 starts:
  - Tile 0: addr 0x010..0x013, we=01.
  - Tile 1: addr 0x010..0x013, we=10.
  - Tile 2: addr 0x018.., we=01.
  - write_done 4 times; tile_count=4.
- len=4 with in_valid pattern 1,0,0,1,1,0,1: exactly 4 writes at offsets 0..3 only on valid cycles; write_done one cycle after the 4th beat.
- base=0x7FE, len=4, ADDR_WIDTH=11: addresses 0x7FE, 0x7FF, 0x000, 0x001.
- reset_addr_counter pulsed at beat 2 of a burst, cfg_base=0x100:
  - The current burst completes at the old base.
  - The next tile starts at 0x100 on bank 0.
  - tile_count=0 after that DONE.
- abort at beat 2 of len=8: the state is IDLE next cycle, no write_done, and the restarted tile reuses the same base and bank.
- start with cfg_burst_len=0, start during WRITING/DONE, and rst asserted mid-burst: all starts ignored, and rst returns every output to its reset value next cycle.

Source files
------------

// File: rtl/write_gen_pkg.sv
// Shared types and width helpers for the tile write-burst generator.
package write_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WRITING = 2'b01,
    DONE    = 2'b10
  } state_e;

  // Bank index needs at least one bit even for a single bank.
  function automatic int unsigned bank_w(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int unsigned len_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/write_burst_gen_if.sv
// Upstream beat handshake plus BRAM address/enable bus for the write generator.
interface write_burst_gen_if
  import write_gen_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned ADDR_WIDTH = 11
);
  localparam int unsigned BANK_W = bank_w(NUM_BANKS);

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [NUM_BANKS-1:0]  bram_we;
  logic [BANK_W-1:0]     bank_sel;

  modport master (input in_valid, output in_ready, bram_addr, bram_we, bank_sel);
  modport slave  (output in_valid, input in_ready, bram_addr, bram_we, bank_sel);
endinterface

// File: rtl/write_tile_ptr.sv
// Tile base / bank rotation / completed-tile bookkeeping with deferred reload.
module write_tile_ptr
  import write_gen_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned TILE_CNT_W = 16,
  localparam int unsigned BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_tile_stride,
  input  logic                  advance,
  input  logic                  reload,
  input  logic                  pend_set,
  output logic [ADDR_WIDTH-1:0] tile_base,
  output logic [BANK_W-1:0]     bank_ptr,
  output logic [TILE_CNT_W-1:0] tile_count,
  output logic                  pending_rst
);

  // A reload always takes priority over the end-of-tile advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_base   <= '0;
      bank_ptr    <= '0;
      tile_count  <= '0;
      pending_rst <= 1'b0;
    end else begin
      if (reload) begin
        tile_base  <= cfg_base_addr;
        bank_ptr   <= '0;
        tile_count <= '0;
      end else if (advance) begin
        tile_count <= tile_count + TILE_CNT_W'(1);
        if (bank_ptr == BANK_W'(NUM_BANKS - 1)) begin
          bank_ptr  <= '0;
          tile_base <= tile_base + cfg_tile_stride;
        end else begin
          bank_ptr <= bank_ptr + BANK_W'(1);
        end
      end
      if (reload)        pending_rst <= 1'b0;
      else if (pend_set) pending_rst <= 1'b1;
    end
  end

endmodule

// File: rtl/write_burst_gen.sv
// BRAM write-burst generator: one tile per start, banks rotate per tile.
module write_burst_gen
  import write_gen_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned TILE_CNT_W = 16,
  localparam int unsigned LEN_W     = len_w(MAX_BURST),
  localparam int unsigned BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_write,
  input  logic                  reset_addr_counter,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]      cfg_burst_len,
  input  logic [ADDR_WIDTH-1:0] cfg_tile_stride,
  write_burst_gen_if.master     bus,
  output logic                  busy,
  output logic                  write_done,
  output logic [TILE_CNT_W-1:0] tile_count
);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      offset_q, len_q;
  logic [ADDR_WIDTH-1:0] tile_base;
  logic [BANK_W-1:0]     bank_ptr;
  logic                  pending_rst;
  logic                  beat_c, last_c, len_ok_c;
  logic                  advance_c, reload_c, pend_set_c;

  assign last_c   = (offset_q == len_q - LEN_W'(1));
  assign len_ok_c = (cfg_burst_len != '0) && (cfg_burst_len <= LEN_W'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake, write-enable decode and pointer control.
  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.bram_we  = '0;
    beat_c       = 1'b0;
    advance_c    = 1'b0;
    reload_c     = 1'b0;
    pend_set_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        reload_c = reset_addr_counter;
        if (start_write && len_ok_c) state_d = WRITING;
      end
      WRITING: begin
        bus.in_ready = 1'b1;
        beat_c       = bus.in_valid;
        if (beat_c) bus.bram_we = NUM_BANKS'(1) << bank_ptr;
        if (abort) begin
          state_d  = IDLE;
          reload_c = reset_addr_counter;
        end else begin
          pend_set_c = reset_addr_counter;
          if (beat_c && last_c) state_d = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        advance_c = 1'b1;
        reload_c  = reset_addr_counter || pending_rst;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      len_q    <= '0;
    end else begin
      if (state_q == IDLE && state_d == WRITING) len_q <= cfg_burst_len;
      if (state_q == DONE || (state_q == WRITING && abort)) offset_q <= '0;
      else if (beat_c)                                     offset_q <= offset_q + LEN_W'(1);
    end
  end

  write_tile_ptr #(
    .NUM_BANKS (NUM_BANKS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TILE_CNT_W(TILE_CNT_W)
  ) u_ptr (
    .clk            (clk),
    .rst            (rst),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_tile_stride(cfg_tile_stride),
    .advance        (advance_c),
    .reload         (reload_c),
    .pend_set       (pend_set_c),
    .tile_base      (tile_base),
    .bank_ptr       (bank_ptr),
    .tile_count     (tile_count),
    .pending_rst    (pending_rst)
  );

  assign bus.bram_addr = tile_base + ADDR_WIDTH'(offset_q);
  assign bus.bank_sel  = bank_ptr;
  assign busy          = (state_q == WRITING) || (state_q == DONE);
  assign write_done    = (state_q == DONE);

endmodule

// File: tb/tb_write_burst_gen.sv
// Randomized scoreboard bench for write_burst_gen against a tile-level reference model.
module tb_write_burst_gen;
  import write_gen_pkg::*;

  localparam int unsigned NB = 2;
  localparam int unsigned AW = 11;
  localparam int unsigned MB = 16;
  localparam int unsigned TW = 16;
  localparam int unsigned LW = len_w(MB);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_write, reset_addr_counter, abort;
  logic [AW-1:0] cfg_base_addr, cfg_tile_stride;
  logic [LW-1:0] cfg_burst_len;
  logic          busy, write_done;
  logic [TW-1:0] tile_count;

  always #5 clk = ~clk;

  write_burst_gen_if #(.NUM_BANKS(NB), .ADDR_WIDTH(AW)) bus ();

  write_burst_gen #(
    .NUM_BANKS(NB), .ADDR_WIDTH(AW), .MAX_BURST(MB), .TILE_CNT_W(TW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_write       (start_write),
    .reset_addr_counter(reset_addr_counter),
    .abort             (abort),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_burst_len     (cfg_burst_len),
    .cfg_tile_stride   (cfg_tile_stride),
    .bus               (bus.master),
    .busy              (busy),
    .write_done        (write_done),
    .tile_count        (tile_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [NB-1:0] we;
    logic          bank;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: tile-level pointer state
  logic [AW-1:0] m_base;
  int            m_bank;
  int            m_cnt;
  bit            m_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_base = '0; m_bank = 0; m_cnt = 0; m_pend = 0;
  endfunction

  function automatic void model_reload();
    m_base = cfg_base_addr; m_bank = 0; m_cnt = 0; m_pend = 0;
  endfunction

  function automatic void model_done(input bit rac_now);
    if (rac_now || m_pend) model_reload();
    else begin
      m_cnt = (m_cnt + 1) % (1 << TW);
      if (m_bank == NB - 1) begin
        m_bank = 0;
        m_base = m_base + cfg_tile_stride;
      end else m_bank++;
    end
  endfunction

  function automatic void push_beat(input int i);
    wr_t e;
    logic [AW-1:0] off;
    off    = AW'(i);
    e.addr = m_base + off;
    e.we   = NB'(1) << m_bank;
    e.bank = 1'(m_bank);
    exp_q.push_back(e);
  endfunction

  // Monitor: every write and every write_done must match a queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bram_we != '0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got we=%0h addr=%0h expected none", bus.bram_we, bus.bram_addr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("bram_addr", 32'(bus.bram_addr), 32'(e.addr));
          chk("bram_we",   32'(bus.bram_we),   32'(e.we));
          chk("bank_sel",  32'(bus.bank_sel),  32'(e.bank));
        end
      end
      if (write_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write_done: got 1 expected 0 at %0t", $time);
        end else chk("tile_count_at_done", 32'(tile_count), 32'(done_q.pop_front()));
      end
    end
  end

  // Issue one tile starting from IDLE (called at posedge+1), randomized valid stalls.
  task automatic run_tile(input int len, input int abort_beat, input int rac_beat,
                          input bit rac_done, input int vprob);
    int beats = 0;
    bit aborted = 0;
    bit v;
    cfg_burst_len = LW'(len);
    start_write   = 1'b1;
    @(posedge clk); #1;
    start_write = 1'b0;
    for (int cyc = 0; cyc < 2000 && beats < len && !aborted; cyc++) begin
      v            = ($urandom_range(0, 99) < vprob);
      bus.in_valid = v;
      start_write  = ($urandom_range(0, 7) == 0);
      if (v) begin
        push_beat(beats);
        if (beats == abort_beat) abort = 1'b1;
        if (beats == rac_beat) begin
          reset_addr_counter = 1'b1;
          if (abort_beat != rac_beat) m_pend = 1;
        end
      end
      @(negedge clk);
      chk("in_ready_writing", 32'(bus.in_ready), 32'd1);
      chk("busy_writing",     32'(busy),         32'd1);
      @(posedge clk); #1;
      if (v) begin
        if (abort) begin
          aborted = 1;
          if (reset_addr_counter) model_reload();
        end
        beats++;
      end
      abort = 1'b0; reset_addr_counter = 1'b0; bus.in_valid = 1'b0; start_write = 1'b0;
    end
    if (!aborted) begin
      chk("burst_completed", 32'(beats), 32'(len));
      done_q.push_back(m_cnt);
      reset_addr_counter = rac_done;
      start_write        = 1'b1;
      @(negedge clk);
      chk("in_ready_done", 32'(bus.in_ready), 32'd0);
      chk("busy_done",     32'(busy),         32'd1);
      @(posedge clk); #1;
      model_done(rac_done);
      reset_addr_counter = 1'b0; start_write = 1'b0;
    end
    @(negedge clk);
    chk("busy_idle",       32'(busy),       32'd0);
    chk("tile_count_idle", 32'(tile_count), 32'(m_cnt));
    @(posedge clk); #1;
  endtask

  task automatic idle_reload(input logic [AW-1:0] base);
    cfg_base_addr      = base;
    reset_addr_counter = 1'b1;
    @(posedge clk); #1;
    reset_addr_counter = 1'b0;
    model_reload();
  endtask

  task automatic bad_start(input int len);
    cfg_burst_len = LW'(len);
    start_write   = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    start_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("busy_bad_start", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int len, ab, rb;
    rst = 1'b1; start_write = 0; reset_addr_counter = 0; abort = 0;
    cfg_base_addr = '0; cfg_tile_stride = AW'(8); cfg_burst_len = LW'(4);
    bus.in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",       32'(busy),          32'd0);
    chk("rst_write_done", 32'(write_done),    32'd0);
    chk("rst_in_ready",   32'(bus.in_ready),  32'd0);
    chk("rst_we",         32'(bus.bram_we),   32'd0);
    chk("rst_addr",       32'(bus.bram_addr), 32'd0);
    chk("rst_bank",       32'(bus.bank_sel),  32'd0);
    chk("rst_tile_count", 32'(tile_count),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Bank rotation and stride advance
    idle_reload(AW'(11'h010));
    repeat (4) run_tile(4, -1, -1, 0, 100);
    chk("tile_count_after_4", 32'(tile_count), 32'd4);

    run_tile(4, -1, -1, 0, 50);
    idle_reload(AW'(11'h7FE));
    run_tile(4, -1, -1, 0, 100);

    // Deferred reload mid-burst, then the next tile starts at the new base
    cfg_base_addr = AW'(11'h100);
    run_tile(4, -1, 2, 0, 100);
    chk("tile_count_after_reload", 32'(tile_count), 32'd0);
    run_tile(4, -1, -1, 0, 100);

    // Abort then restart on the same base/bank
    run_tile(8, 2, -1, 0, 100);
    run_tile(8, -1, -1, 0, 100);

    bad_start(0);
    bad_start(20);

    for (int t = 0; t < 40; t++) begin
      len             = $urandom_range(1, MB);
      cfg_tile_stride = AW'($urandom);
      cfg_base_addr   = AW'($urandom);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
      if ($urandom_range(0, 5) == 0) rb = (ab >= 0) ? ab : $urandom_range(0, len - 1);
      else rb = -1;
      run_tile(len, ab, rb, ($urandom_range(0, 7) == 0), $urandom_range(20, 100));
    end

    // Synchronous reset in the middle of a burst
    cfg_burst_len = LW'(8);
    start_write   = 1'b1;
    @(posedge clk); #1;
    start_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      push_beat(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    model_reset();
    chk("midrst_busy",       32'(busy),          32'd0);
    chk("midrst_in_ready",   32'(bus.in_ready),  32'd0);
    chk("midrst_addr",       32'(bus.bram_addr), 32'd0);
    chk("midrst_bank",       32'(bus.bank_sel),  32'd0);
    chk("midrst_tile_count", 32'(tile_count),    32'd0);
    chk("midrst_write_done", 32'(write_done),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_tile(3, -1, -1, 0, 100);

    repeat (3) @(posedge clk);
    chk("pending_writes_left", 32'(exp_q.size()),  32'd0);
    chk("pending_dones_left",  32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
